// File: rtl/wdt32_core.sv
// Two-stage watchdog counter. The first timeout sets WDOV, a second timeout with WDOV
// still set latches RST_REQ. Counting is paced by a PRESCALE-cycle tick.
module wdt32_core #(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned PRE_W    = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [31:0] WDLOAD,
  input  logic        WDEN,
  input  logic        WDOVCLR,
  output logic [31:0] WDTMR,
  output logic        WDOV,
  output logic        RST_REQ
);

  typedef enum logic [1:0] {StDis, StRun, StExp, StRstq} state_e;

  localparam logic [PRE_W-1:0] PreMax = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] PreOne = PRE_W'(1);

  state_e             state_q, state_d;
  logic [31:0]        tmr_q, tmr_d;
  logic               ov_q, ov_d;
  logic               rr_q, rr_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               wden_q, clr_q;
  logic [31:0]        load_q;

  logic en_rise, en_fall, clr_rise, load_chg, running, tick;

  assign en_rise  = WDEN & ~wden_q;
  assign en_fall  = ~WDEN & wden_q;
  assign clr_rise = WDOVCLR & ~clr_q;
  assign load_chg = (WDLOAD != load_q);
  assign running  = (state_q == StRun) || (state_q == StExp);
  assign tick     = (pre_q == PreMax);

  // Next-state: one prioritised action per cycle; RSTQ holds everything until reset.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    ov_d    = ov_q;
    rr_d    = rr_q;
    pre_d   = pre_q;
    if (state_q != StRstq) begin
      if (en_fall) begin
        state_d = StDis;
        pre_d   = '0;
      end else if (en_rise && (state_q == StDis)) begin
        tmr_d   = WDLOAD;
        pre_d   = '0;
        state_d = ov_q ? StExp : StRun;
      end else if (clr_rise) begin
        // Clear wins over a same-cycle timeout; while disabled only the flag clears.
        ov_d = 1'b0;
        if (running) begin
          tmr_d   = WDLOAD;
          pre_d   = '0;
          state_d = StRun;
        end
      end else if (load_chg && running) begin
        tmr_d = WDLOAD;
        pre_d = '0;
      end else if (running) begin
        if (tick) begin
          pre_d = '0;
          if (tmr_q != 32'd0) begin
            tmr_d = tmr_q - 32'd1;
          end else begin
            tmr_d = WDLOAD;
            if (state_q == StRun) begin
              state_d = StExp;
              ov_d    = 1'b1;
            end else begin
              state_d = StRstq;
              rr_d    = 1'b1;
            end
          end
        end else begin
          pre_d = pre_q + PreOne;
        end
      end
    end
  end

  // State and input-history registers; load_q tracks WDLOAD in every state.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StDis;
      tmr_q   <= '0;
      ov_q    <= 1'b0;
      rr_q    <= 1'b0;
      pre_q   <= '0;
      wden_q  <= 1'b0;
      clr_q   <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ov_q    <= ov_d;
      rr_q    <= rr_d;
      pre_q   <= pre_d;
      wden_q  <= WDEN;
      clr_q   <= WDOVCLR;
      load_q  <= WDLOAD;
    end
  end

  assign WDTMR   = tmr_q;
  assign WDOV    = ov_q;
  assign RST_REQ = rr_q;

endmodule

// File: tb/tb_wdt32_core.sv
// Bench for wdt32_core: a PRESCALE=1 and a PRESCALE=4 instance share the inputs.
module tb_wdt32_core;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [31:0] WDLOAD;
  logic        WDEN;
  logic        WDOVCLR;
  logic [31:0] tmr1, tmr4;
  logic        ov1, ov4, rr1, rr4;

  always #5 PCLK = ~PCLK;

  wdt32_core #(.PRESCALE(1), .PRE_W(16)) dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .WDLOAD(WDLOAD), .WDEN(WDEN), .WDOVCLR(WDOVCLR),
    .WDTMR(tmr1), .WDOV(ov1), .RST_REQ(rr1)
  );

  wdt32_core #(.PRESCALE(4), .PRE_W(16)) dut4 (
    .PCLK(PCLK), .PRESETn(PRESETn), .WDLOAD(WDLOAD), .WDEN(WDEN), .WDOVCLR(WDOVCLR),
    .WDTMR(tmr4), .WDOV(ov4), .RST_REQ(rr4)
  );

  typedef struct {
    logic        sel4;
    logic [31:0] tmr;
    logic        ov;
    logic        rr;
  } exp_t;

  typedef struct {
    logic        en;
    logic        clr;
    logic [31:0] load;
    logic [31:0] tmr;
    logic        ov;
    logic        rr;
  } vec_t;

  exp_t  sb[$];
  vec_t  tbl[14];
  int    n_tests  = 0;
  int    n_failed = 0;
  string tag      = "init";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: pop one expectation per edge and compare just after the edge.
  always @(posedge PCLK) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.sel4) begin
        chk({tag, " WDTMR(P4)"}, tmr4, e.tmr);
        chk({tag, " WDOV(P4)"}, {31'd0, ov4}, {31'd0, e.ov});
        chk({tag, " RST_REQ(P4)"}, {31'd0, rr4}, {31'd0, e.rr});
      end else begin
        chk({tag, " WDTMR"}, tmr1, e.tmr);
        chk({tag, " WDOV"}, {31'd0, ov1}, {31'd0, e.ov});
        chk({tag, " RST_REQ"}, {31'd0, rr1}, {31'd0, e.rr});
      end
    end
  end

  task automatic step(input logic en, input logic clr, input logic [31:0] load,
                      input logic [31:0] etmr, input logic eov, input logic err,
                      input logic sel4);
    exp_t e;
    WDEN    = en;
    WDOVCLR = clr;
    WDLOAD  = load;
    e.sel4  = sel4;
    e.tmr   = etmr;
    e.ov    = eov;
    e.rr    = err;
    sb.push_back(e);
    @(posedge PCLK);
    #2;
  endtask

  task automatic do_reset(input logic [31:0] load);
    WDEN    = 1'b0;
    WDOVCLR = 1'b0;
    WDLOAD  = load;
    PRESETn = 1'b0;
    #3;
    chk("reset WDTMR", tmr1, 32'd0);
    chk("reset WDOV", {31'd0, ov1}, 32'd0);
    chk("reset RST_REQ", {31'd0, rr1}, 32'd0);
    chk("reset WDTMR(P4)", tmr4, 32'd0);
    @(posedge PCLK);
    #2;
    PRESETn = 1'b1;
  endtask

  initial begin
    logic [31:0] e;
    logic [31:0] ld;

    // Countdown, first timeout, second timeout, then RSTQ ignores all inputs.
    tbl[0]  = '{1'b0, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'd3, 32'd3, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'd3, 32'd2, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'd3, 32'd1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'd3, 32'd3, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 32'd3, 32'd2, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'd3, 32'd1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'd3, 32'd0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'd3, 32'd3, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 32'd3, 32'd3, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 32'd3, 32'd3, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 32'd9, 32'd3, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 32'd5, 32'd3, 1'b1, 1'b1};

    tag = "reset";
    do_reset(32'd3);
    tag = "table";
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].en, tbl[i].clr, tbl[i].load, tbl[i].tmr, tbl[i].ov, tbl[i].rr, 1'b0);
    end

    // PRESCALE=4: WDTMR steps every 4 cycles, WDOV exactly 12 cycles after enable.
    tag = "prescale4";
    do_reset(32'd2);
    step(1'b1, 1'b0, 32'd2, 32'd2, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 1'b0, 32'd2, (k < 12) ? 32'(2 - k / 4) : 32'd2, (k >= 12), 1'b0, 1'b1);
    end

    // Clear coincides with a due EXP timeout; holding clear high does nothing more.
    tag = "clr_vs_timeout";
    do_reset(32'd3);
    step(1'b1, 1'b0, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k >= 0; k--) step(1'b1, 1'b0, 32'd3, 32'(k), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0);
    for (int k = 2; k >= 0; k--) step(1'b1, 1'b0, 32'd3, 32'(k), 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k >= 0; k--) step(1'b1, 1'b1, 32'd3, 32'(k), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0);

    // Refresh by rewriting WDLOAD keeps WDOV clear.
    tag = "load_refresh";
    do_reset(32'd100);
    step(1'b1, 1'b0, 32'd100, 32'd100, 1'b0, 1'b0, 1'b0);
    e = 32'd100;
    for (int i = 0; i < 95; i++) begin
      e = e - 32'd1;
      step(1'b1, 1'b0, 32'd100, e, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 32'd200, 32'd200, 1'b0, 1'b0, 1'b0);
    ld = 32'd200;
    e  = 32'd200;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 49; i++) begin
        e = e - 32'd1;
        step(1'b1, 1'b0, ld, e, 1'b0, 1'b0, 1'b0);
      end
      ld = (ld == 32'd200) ? 32'd201 : 32'd200;
      e  = ld;
      step(1'b1, 1'b0, ld, e, 1'b0, 1'b0, 1'b0);
    end

    // Disable with WDOV set freezes the count; re-enable resumes in EXP.
    tag = "disable_reenable";
    do_reset(32'd10);
    step(1'b1, 1'b0, 32'd10, 32'd10, 1'b0, 1'b0, 1'b0);
    for (int k = 9; k >= 0; k--) step(1'b1, 1'b0, 32'd10, 32'(k), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd10, 32'd10, 1'b1, 1'b0, 1'b0);
    for (int k = 9; k >= 7; k--) step(1'b1, 1'b0, 32'd10, 32'(k), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'd10, 32'd7, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'd10, 32'd7, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd10, 32'd10, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd10, 32'd9, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd10, 32'd8, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-count, checked before any further clock edge.
    tag = "async_reset";
    #2;
    PRESETn = 1'b0;
    #1;
    chk("async_reset WDTMR", tmr1, 32'd0);
    chk("async_reset WDOV", {31'd0, ov1}, 32'd0);
    chk("async_reset RST_REQ", {31'd0, rr1}, 32'd0);
    WDEN = 1'b0;
    @(posedge PCLK);
    #2;
    PRESETn = 1'b1;
    step(1'b0, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd10, 32'd10, 1'b0, 1'b0, 1'b0);

    #10;
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
